// File: rtl/delay_pulse_checker.sv
// Receive-side monitor for the periodic delay pulse stream: locks on the first pulse, then
// checks each inter-pulse gap against N+1 +/- TOL. Optional last_gap port: DELAY_CHK_PERIOD_CAPTURE_EN.
module delay_pulse_checker #(
    parameter int N     = 17500,
    parameter int CBITS = 15,
    parameter int TOL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             locked,
    output logic             ok,
    output logic             win,
    output logic             err,
    output logic             err_early,
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
    output logic             err_late,
    output logic [CBITS-1:0] last_gap
`else
    output logic             err_late
`endif
);

    localparam logic [CBITS-1:0] ONE = CBITS'(1);
    localparam logic [CBITS-1:0] LO  = CBITS'(N + 1 - TOL);
    localparam logic [CBITS-1:0] HI  = CBITS'(N + 1 + TOL);

    typedef enum logic [1:0] {ACQ, LOCK, FAULT} state_t;

    state_t           state_reg, state_next;
    logic [CBITS-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             ok_next, early_next, late_next, win_next;

    always_comb begin
        cnt_inc    = (cnt_reg == '1) ? cnt_reg : cnt_reg + ONE;
        cnt_next   = sig_in ? ONE : cnt_inc;
        state_next = state_reg;
        ok_next    = 1'b0;
        early_next = 1'b0;
        late_next  = 1'b0;
        case (state_reg)
            ACQ: begin
                if (sig_in)
                    state_next = LOCK;
            end
            LOCK: begin
                // cnt can never exceed HI here: the late fault fires as cnt reaches HI.
                if (sig_in) begin
                    if (cnt_reg < LO) begin
                        state_next = FAULT;
                        early_next = 1'b1;
                    end else begin
                        ok_next = 1'b1;
                    end
                end else if (cnt_reg == HI) begin
                    state_next = FAULT;
                    late_next  = 1'b1;
                end
            end
            FAULT: begin
                if (sig_in)
                    state_next = LOCK;
            end
            default: state_next = ACQ;
        endcase
        // Registered window flag tracks the state/count that will be current after this edge.
        win_next = (state_next == LOCK) && (cnt_next >= LO) && (cnt_next <= HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACQ;
            cnt_reg   <= '0;
            locked    <= 1'b0;
            ok        <= 1'b0;
            win       <= 1'b0;
            err       <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            locked    <= (state_next == LOCK);
            ok        <= ok_next;
            win       <= win_next;
            if (early_next)
                err_early <= 1'b1;
            if (late_next)
                err_late <= 1'b1;
            if (early_next || late_next)
                err <= 1'b1;
        end
    end

`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
    // Captures the gap of every checked or re-acquiring pulse, faulting ones included.
    always_ff @(posedge clk) begin
        if (rst)
            last_gap <= '0;
        else if (sig_in && (state_reg != ACQ))
            last_gap <= cnt_reg;
    end
`endif

endmodule

// File: tb/tb_delay_pulse_checker.sv
// Directed bench for delay_pulse_checker with N=8, TOL=1, CBITS=5 (window 8..10).
module tb_delay_pulse_checker;

    localparam int N     = 8;
    localparam int CBITS = 5;
    localparam int TOL   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic locked, ok, win, err, err_early, err_late;
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
    logic [CBITS-1:0] last_gap;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    delay_pulse_checker #(.N(N), .CBITS(CBITS), .TOL(TOL)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .locked    (locked),
        .ok        (ok),
        .win       (win),
        .err       (err),
        .err_early (err_early),
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        .err_late  (err_late),
        .last_gap  (last_gap)
`else
        .err_late  (err_late)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Drive sig_in for one sample edge; outputs are observed 1 time unit after that edge.
    task automatic cycle_with(input logic s);
        sig_in = s;
        @(posedge clk);
        #1;
        sig_in = 1'b0;
    endtask

    // Pulse sampled exactly 'gap' edges after the previous pulse sample.
    task automatic send_gap(input int gap);
        repeat (gap - 1) cycle_with(1'b0);
        cycle_with(1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".locked"}, 32'(locked), 0);
        check({tag, ".ok"}, 32'(ok), 0);
        check({tag, ".win"}, 32'(win), 0);
        check({tag, ".err"}, 32'(err), 0);
        check({tag, ".err_early"}, 32'(err_early), 0);
        check({tag, ".err_late"}, 32'(err_late), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) cycle_with(1'b0);
        rst = 1'b0;
        check_all_zero("reset");
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        check("reset.last_gap", 32'(last_gap), 0);
`endif

        // 1: acquire, then gaps of 9 accepted
        send_gap(3);
        check("t1.acq.locked", 32'(locked), 1);
        check("t1.acq.ok", 32'(ok), 0);
        for (int i = 2; i <= 4; i++) begin
            send_gap(9);
            check($sformatf("t1.p%0d.ok", i), 32'(ok), 1);
            check($sformatf("t1.p%0d.err", i), 32'(err), 0);
        end
        repeat (6) cycle_with(1'b0);
        check("t1.cnt7.win", 32'(win), 0);
        check("t1.cnt7.ok", 32'(ok), 0);
        cycle_with(1'b0);
        check("t1.cnt8.win", 32'(win), 1);
        cycle_with(1'b0);
        cycle_with(1'b1);
        check("t1.p5.ok", 32'(ok), 1);
        check("t1.p5.locked", 32'(locked), 1);
        cycle_with(1'b0);
        check("t1.ok_drop", 32'(ok), 0);

        // 2: early pulse at gap 7 (one idle already spent above)
        send_gap(6);
        check("t2.err_early", 32'(err_early), 1);
        check("t2.err", 32'(err), 1);
        check("t2.err_late", 32'(err_late), 0);
        check("t2.locked", 32'(locked), 0);
        check("t2.ok", 32'(ok), 0);

        // 3: fresh lock, gaps 8 and 10 accepted, then late fault
        rst = 1'b1;
        cycle_with(1'b0);
        rst = 1'b0;
        check("t3.rst.err", 32'(err), 0);
        send_gap(2);
        check("t3.acq.locked", 32'(locked), 1);
        send_gap(8);
        check("t3.gap8.ok", 32'(ok), 1);
        send_gap(10);
        check("t3.gap10.ok", 32'(ok), 1);
        repeat (9) cycle_with(1'b0);
        check("t3.cnt10.win", 32'(win), 1);
        check("t3.cnt10.locked", 32'(locked), 1);
        check("t3.cnt10.err_late", 32'(err_late), 0);
        cycle_with(1'b0);
        check("t3.late.err_late", 32'(err_late), 1);
        check("t3.late.err", 32'(err), 1);
        check("t3.late.locked", 32'(locked), 0);
        check("t3.late.win", 32'(win), 0);

        // 4: re-acquire from FAULT, sticky errors remain
        send_gap(9);
        check("t4.reacq.locked", 32'(locked), 1);
        check("t4.reacq.ok", 32'(ok), 0);
        for (int i = 2; i <= 3; i++) begin
            send_gap(9);
            check($sformatf("t4.p%0d.ok", i), 32'(ok), 1);
        end
        check("t4.err", 32'(err), 1);
        check("t4.err_late", 32'(err_late), 1);
        check("t4.err_early", 32'(err_early), 0);

        // 5: rst together with sig_in while locked
        rst = 1'b1;
        cycle_with(1'b1);
        rst = 1'b0;
        check_all_zero("t5.rst");
        send_gap(9);
        check("t5.acq.locked", 32'(locked), 1);
        check("t5.acq.ok", 32'(ok), 0);
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        check("t5.acq.last_gap", 32'(last_gap), 0);
`endif

        // 6: gap 9 then 7, then long idle in FAULT with saturated counter
        send_gap(9);
        check("t6.gap9.ok", 32'(ok), 1);
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        check("t6.gap9.last_gap", 32'(last_gap), 9);
`endif
        send_gap(7);
        check("t6.gap7.err_early", 32'(err_early), 1);
        check("t6.gap7.locked", 32'(locked), 0);
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        check("t6.gap7.last_gap", 32'(last_gap), 7);
`endif
        repeat (40) cycle_with(1'b0);
        check("t6.idle.err_late", 32'(err_late), 0);
        check("t6.idle.locked", 32'(locked), 0);
        check("t6.idle.win", 32'(win), 0);
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        check("t6.idle.last_gap", 32'(last_gap), 7);
`endif
        // Re-acquire with a saturated counter, then a back-to-back pulse is early
        cycle_with(1'b1);
        check("t6.reacq.locked", 32'(locked), 1);
        check("t6.reacq.ok", 32'(ok), 0);
        check("t6.reacq.err_late", 32'(err_late), 0);
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        check("t6.reacq.last_gap", 32'(last_gap), 31);
`endif
        cycle_with(1'b1);
        check("t6.b2b.locked", 32'(locked), 0);
        check("t6.b2b.ok", 32'(ok), 0);
`ifdef DELAY_CHK_PERIOD_CAPTURE_EN
        check("t6.b2b.last_gap", 32'(last_gap), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
